// File: rtl/aes_pkg.sv
// AES-128 shared types, constant tables and round primitives.
// State and key words are FIPS-197 byte order: byte 0 in bits [127:120].
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_arr_t [16];
    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN} ctrl_t;

    // Byte 0x00 maps to the top byte of the flat table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON_TAB [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {8'hff - b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic byte_arr_t to_bytes(input state_t s);
        byte_arr_t b;
        for (int i = 0; i < 16; i++) b[i] = s[8*(15-i) +: 8];
        return b;
    endfunction

    function automatic state_t from_bytes(input byte_arr_t b);
        state_t s;
        for (int i = 0; i < 16; i++) s[8*(15-i) +: 8] = b[i];
        return s;
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        byte_arr_t b;
        b = to_bytes(s);
        for (int i = 0; i < 16; i++) b[i] = sbox(b[i]);
        return from_bytes(b);
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        byte_arr_t b;
        byte_arr_t o;
        b = to_bytes(s);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[r + 4*c] = b[r + 4*((c + r) % 4)];
        return from_bytes(o);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t mix_columns(input state_t s);
        byte_arr_t b;
        byte_arr_t o;
        b = to_bytes(s);
        for (int c = 0; c < 4; c++) begin
            o[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            o[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
        end
        return from_bytes(o);
    endfunction

    function automatic state_t key_next(input state_t k, input logic [7:0] rcon);
        logic [31:0] w_rot;
        logic [31:0] w_tmp;
        logic [31:0] n0, n1, n2, n3;
        w_rot = {k[23:0], k[31:24]};
        w_tmp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                ^ {rcon, 24'h000000};
        n0 = k[127:96] ^ w_tmp;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One registered AES-128 round that also expands its own round key.
// Registers load only when the incoming stage is valid, so an idle stage holds.
module aes_round
    import aes_pkg::*;
#(
    parameter bit         FINAL = 1'b0,
    parameter logic [7:0] RCON  = 8'h01
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  state_t i_state,
    input  state_t i_key,
    output state_t o_state,
    output state_t o_key
);

    state_t w_rkey;
    state_t w_shifted;
    state_t w_mixed;
    state_t r_state;
    state_t r_key;

    always_comb begin
        w_rkey    = key_next(i_key, RCON);
        w_shifted = shift_rows(sub_bytes(i_state));
        w_mixed   = FINAL ? w_shifted : mix_columns(w_shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
        end else if (i_valid) begin
            r_state <= w_mixed ^ w_rkey;
            r_key   <= w_rkey;
        end
    end

    assign o_state = r_state;
    assign o_key   = r_key;

endmodule

// File: rtl/aes_main.sv
// Fully pipelined AES-128 encryptor: stage 0 whitening, ten round stages,
// and a job controller that streams data_total blocks after a start pulse.
module aes_main
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [127:0]       data_in,
    input  logic [127:0]       key,
    input  logic               start,
    input  logic signed [31:0] data_total,
    output logic [127:0]       data_out,
    output logic               AES_first_block_finish,
    output logic               AES_final_block_finish
);

    ctrl_t       r_ctrl;
    ctrl_t       w_ctrl_next;
    logic [31:0] r_remain;
    logic [31:0] w_remain_next;
    state_t      r_key;
    state_t      r_s0_state;
    state_t      r_s0_key;
    logic [10:0] r_vld;
    logic [10:0] r_first;
    logic [10:0] r_last;
    logic        w_accept;
    logic        w_s0_valid;
    logic        w_s0_last;
    logic        w_single;
    state_t      w_s0_key;
    state_t      w_state [0:10];
    state_t      w_rkey  [0:10];

    always_comb begin
        w_ctrl_next   = r_ctrl;
        w_remain_next = r_remain;
        w_accept      = 1'b0;
        w_s0_valid    = 1'b0;
        w_s0_last     = 1'b0;
        w_single      = (data_total <= 32'sd1);
        w_s0_key      = r_key;
        case (r_ctrl)
            ST_IDLE: begin
                if (start) begin
                    w_accept      = 1'b1;
                    w_s0_valid    = 1'b1;
                    w_s0_last     = w_single;
                    w_s0_key      = key;
                    w_remain_next = w_single ? 32'd0 : 32'(data_total - 32'sd1);
                    w_ctrl_next   = w_single ? ST_DRAIN : ST_FEED;
                end
            end
            ST_FEED: begin
                w_s0_valid    = 1'b1;
                w_s0_last     = (r_remain == 32'd1);
                w_remain_next = r_remain - 32'd1;
                if (r_remain == 32'd1) w_ctrl_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Idle again as the last block lands in the output stage.
                if (r_vld[9] && r_last[9]) w_ctrl_next = ST_IDLE;
            end
            default: w_ctrl_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= ST_IDLE;
            r_remain   <= '0;
            r_key      <= '0;
            r_s0_state <= '0;
            r_s0_key   <= '0;
            r_vld      <= '0;
            r_first    <= '0;
            r_last     <= '0;
        end else begin
            r_ctrl   <= w_ctrl_next;
            r_remain <= w_remain_next;
            r_vld    <= {r_vld[9:0], w_s0_valid};
            r_first  <= {r_first[9:0], w_accept};
            r_last   <= {r_last[9:0], w_s0_last};
            if (w_accept) r_key <= key;
            if (w_s0_valid) begin
                r_s0_state <= data_in ^ w_s0_key;
                r_s0_key   <= w_s0_key;
            end
        end
    end

    assign w_state[0] = r_s0_state;
    assign w_rkey[0]  = r_s0_key;

    genvar gi;
    generate
        for (gi = 1; gi <= 10; gi++) begin : g_round
            aes_round #(
                .FINAL (gi == 10),
                .RCON  (RCON_TAB[gi])
            ) u_round (
                .clk     (clk),
                .rst     (rst),
                .i_valid (r_vld[gi-1]),
                .i_state (w_state[gi-1]),
                .i_key   (w_rkey[gi-1]),
                .o_state (w_state[gi]),
                .o_key   (w_rkey[gi])
            );
        end
    endgenerate

    assign data_out               = w_state[10];
    assign AES_first_block_finish = r_vld[10] & r_first[10];
    assign AES_final_block_finish = r_vld[10] & r_last[10];

endmodule

// File: tb/tb_aes_main.sv
// Directed bench for aes_main: FIPS-197 vector, 5-block GCM stream,
// back-to-back jobs, ignored start while busy, and mid-stream reset.
module tb_aes_main;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [127:0]       data_in = '0;
    logic [127:0]       key = '0;
    logic               start = 1'b0;
    logic signed [31:0] data_total = 32'sd0;
    logic [127:0]       data_out;
    logic               first_fin;
    logic               final_fin;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] GCM_KEY  = 128'hfeffe9928665731c6d6a8f9467308308;
    localparam logic [127:0] GCM_CTR  = 128'h3bab75780a31c059f83d2a44752f9864;
    localparam logic [127:0] GCM_CT [0:4] = '{
        128'h7dc63b399f2d98d57ab073b6baa4138e,
        128'h55d37bbd9ad21353a6f93a690eca9e0e,
        128'h3836bbf6d696e672946a1a01404fa6d5,
        128'h1dd8a5316ecc35c3e313bca59d2ac94a,
        128'h6742982706a9f154f657d5dc94b746db
    };

    aes_main u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .data_in                (data_in),
        .key                    (key),
        .start                  (start),
        .data_total             (data_total),
        .data_out               (data_out),
        .AES_first_block_finish (first_fin),
        .AES_final_block_finish (final_fin)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_first", {127'h0, first_fin}, 128'h0);
        chk("rst_final", {127'h0, final_fin}, 128'h0);
        rst = 1'b0;
        tick;
        $display("reset released: data_out=%h", data_out);

        // FIPS-197 App.B, single block
        key = FIPS_KEY; data_in = FIPS_PT; data_total = 32'sd1; start = 1'b1;
        tick;
        start = 1'b0; key = rnd128(); data_in = rnd128(); data_total = 32'sd7;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (c < 10) begin
                chk($sformatf("fips_first_early_c%0d", c), {127'h0, first_fin}, 128'h0);
                chk($sformatf("fips_final_early_c%0d", c), {127'h0, final_fin}, 128'h0);
            end else begin
                chk("fips_data_out", data_out, FIPS_CT);
                chk("fips_first", {127'h0, first_fin}, 128'h1);
                chk("fips_final", {127'h0, final_fin}, 128'h1);
            end
        end
        $display("fips block: data_out=%h first=%0b final=%0b", data_out, first_fin, final_fin);
        tick;
        chk("fips_hold_data", data_out, FIPS_CT);
        chk("fips_first_drop", {127'h0, first_fin}, 128'h0);
        chk("fips_final_drop", {127'h0, final_fin}, 128'h0);

        // 5-block stream; start pulses at c=2 and c=6 arrive while busy
        key = GCM_KEY; data_in = GCM_CTR; data_total = 32'sd5; start = 1'b1;
        tick;
        for (int c = 1; c <= 16; c++) begin
            data_in    = (c < 5) ? GCM_CTR + 128'(c) : rnd128();
            start      = (c == 2) || (c == 6);
            key        = start ? rnd128() : GCM_KEY;
            data_total = (c == 2) ? 32'sd1 : 32'sd5;
            tick;
            if (c >= 10 && c <= 14) begin
                chk($sformatf("stream_data_c%0d", c), data_out, GCM_CT[c-10]);
                chk($sformatf("stream_first_c%0d", c), {127'h0, first_fin}, {127'h0, c == 10});
                chk($sformatf("stream_final_c%0d", c), {127'h0, final_fin}, {127'h0, c == 14});
                $display("stream block %0d: data_out=%h first=%0b final=%0b",
                         c - 10, data_out, first_fin, final_fin);
            end else begin
                chk($sformatf("stream_first_idle_c%0d", c), {127'h0, first_fin}, 128'h0);
                chk($sformatf("stream_final_idle_c%0d", c), {127'h0, final_fin}, 128'h0);
                if (c > 14) chk($sformatf("stream_hold_c%0d", c), data_out, GCM_CT[4]);
            end
        end
        start = 1'b0;

        // Back-to-back single-block jobs; second uses a non-positive count
        key = GCM_KEY; data_in = GCM_CTR; data_total = 32'sd1; start = 1'b1;
        tick;
        start = 1'b0; data_in = rnd128();
        for (int c = 1; c <= 10; c++) tick;
        chk("b2b_job1_data", data_out, GCM_CT[0]);
        chk("b2b_job1_first", {127'h0, first_fin}, 128'h1);
        chk("b2b_job1_final", {127'h0, final_fin}, 128'h1);
        $display("b2b job1: data_out=%h", data_out);
        tick;
        key = GCM_KEY; data_in = GCM_CTR + 128'd1; data_total = -32'sd3; start = 1'b1;
        tick;
        start = 1'b0; data_in = rnd128(); key = rnd128();
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (c == 9) begin
                chk("b2b_hold_between", data_out, GCM_CT[0]);
                chk("b2b_first_between", {127'h0, first_fin}, 128'h0);
            end
        end
        chk("b2b_job2_data", data_out, GCM_CT[1]);
        chk("b2b_job2_first", {127'h0, first_fin}, 128'h1);
        chk("b2b_job2_final", {127'h0, final_fin}, 128'h1);
        $display("b2b job2: data_out=%h", data_out);

        // Reset in the middle of a stream
        key = GCM_KEY; data_in = GCM_CTR; data_total = 32'sd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            data_in = GCM_CTR + 128'(c);
            tick;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data_out", data_out, 128'h0);
        chk("midrst_first", {127'h0, first_fin}, 128'h0);
        chk("midrst_final", {127'h0, final_fin}, 128'h0);
        tick;
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick;
            chk($sformatf("post_rst_first_c%0d", c), {127'h0, first_fin}, 128'h0);
            chk($sformatf("post_rst_final_c%0d", c), {127'h0, final_fin}, 128'h0);
            chk($sformatf("post_rst_data_c%0d", c), data_out, 128'h0);
        end
        $display("after mid-stream reset: data_out=%h", data_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
